// File: rtl/tpu_frame_sequencer_pkg.sv
// Shared types and status codes for the TPU frame sequencer.
package tpu_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_BUSY
  } state_t;

  typedef enum logic {
    FT_GRID,
    FT_MOVE
  } frame_t;

  localparam logic [7:0] ST_OK       = 8'hA0;
  localparam logic [7:0] ST_BAD_HDR  = 8'hA1;
  localparam logic [7:0] ST_BAD_LEN  = 8'hA2;
  localparam logic [7:0] ST_BAD_CSUM = 8'hA3;
  localparam logic [7:0] ST_TIMEOUT  = 8'hA4;
  localparam logic [7:0] ST_BUSY     = 8'hA5;

endpackage

// File: rtl/tpu_frame_sequencer_if.sv
// Byte streams between SPI slave, TPU and SPI host around the frame sequencer.
interface tpu_frame_sequencer_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  in_v;
  logic [DATA_WIDTH-1:0] in_d;
  logic                  tpu_iv;
  logic [DATA_WIDTH-1:0] tpu_id;
  logic                  tpu_abort;
  logic                  tpu_done;
  logic                  tpu_ov;
  logic [DATA_WIDTH-1:0] tpu_od;
  logic                  host_busy;
  logic                  out_v;
  logic [DATA_WIDTH-1:0] out_d;

  // master is the sequencer itself; slave is the surrounding environment
  modport master (
    input  in_v, in_d, tpu_done, tpu_ov, tpu_od, host_busy,
    output tpu_iv, tpu_id, tpu_abort, out_v, out_d
  );

  modport slave (
    output in_v, in_d, tpu_done, tpu_ov, tpu_od, host_busy,
    input  tpu_iv, tpu_id, tpu_abort, out_v, out_d
  );
endinterface

// File: rtl/tpu_frame_sequencer_out_mux.sv
// One-entry status register merged behind TPU result bytes onto the host load channel.
module frame_out_mux #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  q_v,
  input  logic [DATA_WIDTH-1:0] q_code,
  input  logic                  tpu_ov,
  input  logic [DATA_WIDTH-1:0] tpu_od,
  input  logic                  host_busy,
  output logic                  out_v,
  output logic [DATA_WIDTH-1:0] out_d
);
  logic                  out_v_reg;
  logic [DATA_WIDTH-1:0] out_d_reg;
  logic [DATA_WIDTH-1:0] status_reg;
  logic                  pending_reg;
  logic                  status_free;

  // a status queued this cycle may leave immediately when the channel is free
  assign status_free = !tpu_ov && !host_busy;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_v_reg   <= 1'b0;
      out_d_reg   <= '0;
      status_reg  <= '0;
      pending_reg <= 1'b0;
    end else begin
      if (tpu_ov) begin
        out_v_reg <= 1'b1;
        out_d_reg <= tpu_od;
      end else if ((q_v || pending_reg) && !host_busy) begin
        out_v_reg <= 1'b1;
        out_d_reg <= q_v ? q_code : status_reg;
      end else begin
        out_v_reg <= 1'b0;
      end
      if (q_v) begin
        status_reg  <= q_code;
        pending_reg <= !status_free;
      end else if (status_free) begin
        pending_reg <= 1'b0;
      end
    end
  end

  assign out_v = out_v_reg;
  assign out_d = out_d_reg;
endmodule

// File: rtl/tpu_frame_sequencer.sv
// Parses HDR/LEN/payload/CSUM frames from the SPI slave, feeds the TPU and reports status.
module tpu_frame_sequencer
  import tpu_frame_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] GRID_HEADER    = 8'b11_01_01_01,
  parameter logic [DATA_WIDTH-1:0] MOVE_HEADER    = 8'b11_10_10_10,
  parameter int                    GRID_BYTES     = 8,
  parameter int                    MAX_MOVES      = 220,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  nrst,
  tpu_frame_sequencer_if.master bus
);
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                state_reg, state_next;
  frame_t                ftype_reg, ftype_next;
  logic [8:0]            cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] csum_reg, csum_next;
  logic [GW-1:0]         gap_reg, gap_next, gap_inc;
  logic                  bad_hdr_seen_reg, bad_hdr_seen_next;
  logic                  busy_drop_reg, busy_drop_next;
  logic                  iv_reg, iv_next;
  logic [DATA_WIDTH-1:0] id_reg, id_next;
  logic                  abort_reg, abort_next;
  logic                  q_v;
  logic [DATA_WIDTH-1:0] q_code;
  logic                  len_ok;
  logic [8:0]            len9;
  logic                  timed_out;

  always_comb begin
    state_next        = state_reg;
    ftype_next        = ftype_reg;
    cnt_next          = cnt_reg;
    csum_next         = csum_reg;
    bad_hdr_seen_next = bad_hdr_seen_reg;
    busy_drop_next    = busy_drop_reg;
    iv_next           = 1'b0;
    id_next           = id_reg;
    abort_next        = 1'b0;
    q_v               = 1'b0;
    q_code            = '0;
    gap_inc           = gap_reg + 1'b1;
    gap_next          = '0;
    len9              = 9'(bus.in_d);
    len_ok            = (ftype_reg == FT_GRID) ? (bus.in_d == DATA_WIDTH'(GRID_BYTES))
                      : ((bus.in_d != '0) && (bus.in_d <= DATA_WIDTH'(MAX_MOVES)));
    timed_out         = !bus.in_v && (gap_inc == GW'(TIMEOUT_CYCLES));

    // the gap counter only runs while a frame is partially received
    if ((state_reg == S_LEN || state_reg == S_PAYLOAD || state_reg == S_CSUM) && !bus.in_v)
      gap_next = gap_inc;

    case (state_reg)
      S_IDLE: begin
        if (bus.in_v) begin
          if (bus.in_d == GRID_HEADER || bus.in_d == MOVE_HEADER) begin
            ftype_next        = (bus.in_d == MOVE_HEADER) ? FT_MOVE : FT_GRID;
            iv_next           = 1'b1;
            id_next           = bus.in_d;
            csum_next         = bus.in_d;
            bad_hdr_seen_next = 1'b0;
            state_next        = S_LEN;
          end else if (!bad_hdr_seen_reg) begin
            q_v               = 1'b1;
            q_code            = DATA_WIDTH'(ST_BAD_HDR);
            bad_hdr_seen_next = 1'b1;
          end
        end
      end
      S_LEN: begin
        if (bus.in_v) begin
          csum_next = csum_reg ^ bus.in_d;
          if (len_ok) begin
            cnt_next   = (ftype_reg == FT_GRID) ? len9 : (len9 << 1);
            state_next = S_PAYLOAD;
          end else begin
            q_v        = 1'b1;
            q_code     = DATA_WIDTH'(ST_BAD_LEN);
            abort_next = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_PAYLOAD: begin
        if (bus.in_v) begin
          iv_next   = 1'b1;
          id_next   = bus.in_d;
          csum_next = csum_reg ^ bus.in_d;
          cnt_next  = cnt_reg - 1'b1;
          if (cnt_reg == 9'd1)
            state_next = S_CSUM;
        end
      end
      S_CSUM: begin
        if (bus.in_v) begin
          if (bus.in_d == csum_reg) begin
            busy_drop_next = 1'b0;
            state_next     = S_BUSY;
          end else begin
            q_v        = 1'b1;
            q_code     = DATA_WIDTH'(ST_BAD_CSUM);
            abort_next = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_BUSY: begin
        if (bus.in_v && !busy_drop_reg) begin
          q_v            = 1'b1;
          q_code         = DATA_WIDTH'(ST_BUSY);
          busy_drop_next = 1'b1;
        end
        // completion outranks a dropped byte in the same cycle
        if (bus.tpu_done) begin
          q_v        = 1'b1;
          q_code     = DATA_WIDTH'(ST_OK);
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if ((state_reg == S_LEN || state_reg == S_PAYLOAD || state_reg == S_CSUM) && timed_out) begin
      q_v        = 1'b1;
      q_code     = DATA_WIDTH'(ST_TIMEOUT);
      abort_next = 1'b1;
      gap_next   = '0;
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg        <= S_IDLE;
      ftype_reg        <= FT_GRID;
      cnt_reg          <= '0;
      csum_reg         <= '0;
      gap_reg          <= '0;
      bad_hdr_seen_reg <= 1'b0;
      busy_drop_reg    <= 1'b0;
      iv_reg           <= 1'b0;
      id_reg           <= '0;
      abort_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      ftype_reg        <= ftype_next;
      cnt_reg          <= cnt_next;
      csum_reg         <= csum_next;
      gap_reg          <= gap_next;
      bad_hdr_seen_reg <= bad_hdr_seen_next;
      busy_drop_reg    <= busy_drop_next;
      iv_reg           <= iv_next;
      id_reg           <= id_next;
      abort_reg        <= abort_next;
    end
  end

  assign bus.tpu_iv    = iv_reg;
  assign bus.tpu_id    = id_reg;
  assign bus.tpu_abort = abort_reg;

  frame_out_mux #(.DATA_WIDTH(DATA_WIDTH)) u_out_mux (
    .clk       (clk),
    .nrst      (nrst),
    .q_v       (q_v),
    .q_code    (q_code),
    .tpu_ov    (bus.tpu_ov),
    .tpu_od    (bus.tpu_od),
    .host_busy (bus.host_busy),
    .out_v     (bus.out_v),
    .out_d     (bus.out_d)
  );
endmodule

// File: tb/tb_tpu_frame_sequencer.sv
// Directed scoreboard bench for tpu_frame_sequencer: TPU-side and host-side byte queues.
module tb_tpu_frame_sequencer;
  localparam int T = 1024;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  tpu_frame_sequencer_if #(.DATA_WIDTH(8)) bus ();

  tpu_frame_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int abort_cnt = 0;
  int exp_aborts = 0;
  logic [7:0] fwd_q[$];
  logic [7:0] out_q[$];
  logic [7:0] pay[$];
  logic s_iv, s_abort, s_out_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock; outputs sampled 1ns after the edge and scored against the queues
  task automatic tick();
    @(posedge clk);
    #1;
    s_iv    = bus.tpu_iv;
    s_abort = bus.tpu_abort;
    s_out_v = bus.out_v;
    if (bus.tpu_iv) begin
      if (fwd_q.size() == 0) chk("tpu_iv_unexpected", {24'd0, bus.tpu_id}, 32'hFFFF);
      else chk("tpu_id", bus.tpu_id, fwd_q.pop_front());
    end
    if (bus.out_v) begin
      if (out_q.size() == 0) chk("out_v_unexpected", {24'd0, bus.out_d}, 32'hFFFF);
      else chk("out_d", bus.out_d, out_q.pop_front());
    end
    if (bus.tpu_abort) begin
      abort_cnt++;
      chk("abort_iv_overlap", bus.tpu_iv, 0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.in_v = 1'b1;
    bus.in_d = b;
    tick();
    bus.in_v = 1'b0;
  endtask

  task automatic pulse_done();
    bus.tpu_done = 1'b1;
    tick();
    bus.tpu_done = 1'b0;
  endtask

  // sends HDR, LEN, pay[] and a correct or corrupted checksum
  task automatic send_frame(input logic [7:0] hdr, input logic [7:0] len, input bit good);
    logic [7:0] cs;
    cs = hdr ^ len;
    foreach (pay[i]) cs ^= pay[i];
    fwd_q.push_back(hdr);
    send_byte(hdr);
    chk("hdr_latency", s_iv, 1);
    send_byte(len);
    chk("len_not_forwarded", s_iv, 0);
    foreach (pay[i]) begin
      fwd_q.push_back(pay[i]);
      send_byte(pay[i]);
    end
    if (!good) begin
      out_q.push_back(8'hA3);
      exp_aborts++;
    end
    send_byte(good ? cs : (cs ^ 8'h5A));
    chk("csum_abort", s_abort, good ? 1'b0 : 1'b1);
  endtask

  task automatic send_bad_len(input logic [7:0] hdr, input logic [7:0] len);
    fwd_q.push_back(hdr);
    send_byte(hdr);
    out_q.push_back(8'hA2);
    exp_aborts++;
    send_byte(len);
    chk("bad_len_abort", s_abort, 1);
    chk("bad_len_status", s_out_v, 1);
  endtask

  task automatic drain(input string tag);
    chk({tag, "_fwd_left"}, fwd_q.size(), 0);
    chk({tag, "_out_left"}, out_q.size(), 0);
    chk({tag, "_aborts"}, abort_cnt, exp_aborts);
    $display("step %s: checks=%0d errors=%0d", tag, checks, errors);
  endtask

  initial begin
    bus.in_v = 1'b0; bus.in_d = '0; bus.tpu_done = 1'b0;
    bus.tpu_ov = 1'b0; bus.tpu_od = '0; bus.host_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tpu_iv", bus.tpu_iv, 0);
    chk("rst_tpu_id", bus.tpu_id, 0);
    chk("rst_tpu_abort", bus.tpu_abort, 0);
    chk("rst_out_v", bus.out_v, 0);
    chk("rst_out_d", bus.out_d, 0);
    nrst = 1'b1;
    tick();

    // grid frame, then completion
    pay.delete();
    repeat (8) pay.push_back(8'h01);
    send_frame(8'hD5, 8'h08, 1'b1);
    repeat (3) tick();
    out_q.push_back(8'hA0);
    pulse_done();
    chk("ok_latency", s_out_v, 1);
    drain("grid");

    // move frame; host bytes during BUSY give a single A5
    pay = '{8'h12, 8'h34};
    send_frame(8'hEA, 8'h01, 1'b1);
    out_q.push_back(8'hA5);
    send_byte(8'h55);
    chk("busy_status", s_out_v, 1);
    send_byte(8'h66);
    chk("busy_second_silent", s_out_v, 0);
    out_q.push_back(8'hA0);
    pulse_done();
    drain("move");

    // bad checksum, then back in IDLE the bad-header flag limits A1 to one
    pay.delete();
    repeat (8) pay.push_back(8'h01);
    send_frame(8'hD5, 8'h08, 1'b0);
    tick();
    chk("abort_single_cycle", s_abort, 0);
    out_q.push_back(8'hA1);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("bad_hdr_once", s_out_v, 0);
    drain("bad_csum");

    // length boundaries
    send_bad_len(8'hEA, 8'h00);
    send_bad_len(8'hD5, 8'h09);
    send_bad_len(8'hEA, 8'd221);
    pay.delete();
    for (int i = 0; i < 440; i++) pay.push_back(8'($urandom_range(0, 255)));
    send_frame(8'hEA, 8'd220, 1'b1);
    out_q.push_back(8'hA0);
    pulse_done();
    drain("len_bounds");

    // timeout after 3 payload bytes, then a normal frame
    fwd_q.push_back(8'hD5);
    send_byte(8'hD5);
    send_byte(8'h08);
    for (int i = 0; i < 3; i++) begin
      fwd_q.push_back(8'(8'h40 + i));
      send_byte(8'(8'h40 + i));
    end
    repeat (T - 1) tick();
    chk("no_early_timeout", abort_cnt, exp_aborts);
    out_q.push_back(8'hA4);
    exp_aborts++;
    tick();
    chk("timeout_abort", s_abort, 1);
    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(8'hEA, 8'h02, 1'b1);
    out_q.push_back(8'hA0);
    pulse_done();
    drain("timeout");

    // status held behind TPU result stream and host_busy
    bus.host_busy = 1'b1;
    send_byte(8'h11);
    chk("status_held_busy", s_out_v, 0);
    for (int i = 0; i < 4; i++) begin
      bus.tpu_ov = 1'b1;
      bus.tpu_od = 8'(8'hC0 + i);
      bus.host_busy = i[0];
      out_q.push_back(8'(8'hC0 + i));
      tick();
    end
    bus.tpu_ov = 1'b0;
    bus.host_busy = 1'b1;
    tick();
    chk("status_wait_host", s_out_v, 0);
    bus.host_busy = 1'b0;
    out_q.push_back(8'hA1);
    tick();
    chk("status_released", s_out_v, 1);
    drain("merge");

    // latest status wins; tpu_done outside BUSY is ignored
    bus.host_busy = 1'b1;
    fwd_q.push_back(8'hEA);
    send_byte(8'hEA);
    exp_aborts++;
    send_byte(8'h00);
    send_byte(8'h33);
    bus.host_busy = 1'b0;
    out_q.push_back(8'hA1);
    tick();
    chk("latest_wins", s_out_v, 1);
    pulse_done();
    tick();
    chk("stray_done", s_out_v, 0);
    drain("overwrite");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
